// File: rtl/mem_stage_if.sv
// Pipeline-side bundle for the memory stage: EX/MEM inputs, stall/flush controls and MEM/WB outputs.
interface mem_stage_if #(
    parameter int word_size = 32,
    parameter int reg_size  = 5
);
    logic                 stall;
    logic                 flush;
    logic [word_size-1:0] AluResult_in;
    logic [word_size-1:0] StoreData_in;
    logic [reg_size-1:0]  destination_reg_in;
    logic [1:0]           mem_control_signals;
    logic [1:0]           mem_size;
    logic                 mem_unsigned;
    logic [1:0]           wb_control_signals_in;

    logic [word_size-1:0] ReadData;
    logic [word_size-1:0] AluResult;
    logic [reg_size-1:0]  destination_reg;
    logic [1:0]           wb_control_signals;
    logic                 misaligned;

    modport master (
        output stall, flush, AluResult_in, StoreData_in, destination_reg_in,
               mem_control_signals, mem_size, mem_unsigned, wb_control_signals_in,
        input  ReadData, AluResult, destination_reg, wb_control_signals, misaligned
    );

    modport slave (
        input  stall, flush, AluResult_in, StoreData_in, destination_reg_in,
               mem_control_signals, mem_size, mem_unsigned, wb_control_signals_in,
        output ReadData, AluResult, destination_reg, wb_control_signals, misaligned
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage with byte/half/word loads and stores plus the MEM/WB register; 1-cycle latency.
// No backpressure out: stall holds the MEM/WB register and blocks stores, flush inserts a bubble.
module mem_stage #(
    parameter int word_size = 32,
    parameter int reg_size  = 5,
    parameter int mem_depth = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_stage_if.slave  bus
);
    localparam int aw = $clog2(mem_depth);

    logic [31:0]   mem [mem_depth];

    logic [aw-1:0] idx;
    logic [1:0]    lane;
    logic          mem_read;
    logic          mem_write;
    logic          misalign;
    logic          do_write;
    logic [3:0]    be;
    logic [31:0]   wdat;
    logic [31:0]   rword;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   ext;
    logic [31:0]   load_dat;

    assign idx       = bus.AluResult_in[aw+1:2];
    assign lane      = bus.AluResult_in[1:0];
    assign mem_read  = bus.mem_control_signals[1];
    assign mem_write = bus.mem_control_signals[0];

    // Size 11 behaves as word, so any size with bit1 set needs full word alignment.
    assign misalign = (mem_read || mem_write) &&
                      (((bus.mem_size == 2'b01) && lane[0]) ||
                       (bus.mem_size[1] && (lane != 2'b00)));

    assign do_write = rst_n && !bus.stall && !bus.flush && mem_write && !misalign;

    always_comb begin
        be   = 4'b0000;
        wdat = '0;
        case (bus.mem_size)
            2'b00: begin
                be   = 4'b0001 << lane;
                wdat = {4{bus.StoreData_in[7:0]}};
            end
            2'b01: begin
                be   = lane[1] ? 4'b1100 : 4'b0011;
                wdat = {2{bus.StoreData_in[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = bus.StoreData_in;
            end
        endcase
    end

    // Array has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    assign rword = mem[idx];
    assign rbyte = rword[{lane, 3'b000} +: 8];
    assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ext = rword;
        case (bus.mem_size)
            2'b00:   ext = bus.mem_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'b01:   ext = bus.mem_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: ext = rword;
        endcase
    end

    // A read+write instruction is treated as a store; its read data is discarded.
    assign load_dat = (mem_read && !mem_write && !misalign) ? ext : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            bus.ReadData           <= '0;
            bus.AluResult          <= '0;
            bus.destination_reg    <= '0;
            bus.wb_control_signals <= 2'b00;
            bus.misaligned         <= 1'b0;
        end else if (!bus.stall) begin
            bus.ReadData           <= load_dat;
            bus.AluResult          <= bus.AluResult_in;
            bus.destination_reg    <= bus.destination_reg_in;
            bus.wb_control_signals <= misalign ? 2'b00 : bus.wb_control_signals_in;
            bus.misaligned         <= misalign;
        end
    end
endmodule
